// File: rtl/fifo_mq_read_sched_if.sv
// ============================================================================
// Module      : fifo_mq_read_sched_if
// Description : Bundle of the FIFO read-port and downstream valid/ready
//               signals handled by the multi-queue read scheduler.
//               master : the scheduler (drives read/read_enable and dout*)
//               slave  : the FIFO + consumer side
//               Signals: fifo_empty, queue_mask, read, read_enable, q,
//                        dout, dout_queue, dout_valid, dout_ready, busy.
//               All [0:N-1] vectors are ascending: bit 0 is queue 0.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fifo_mq_read_sched_if #(
    parameter int NR_OF_QUEUES = 16,
    parameter int A_HI_SIZE    = 4,
    parameter int DATA_WIDTH   = 36
);
    logic [0:NR_OF_QUEUES-1] fifo_empty;
    logic [0:NR_OF_QUEUES-1] queue_mask;
    logic                    read;
    logic [0:NR_OF_QUEUES-1] read_enable;
    logic [DATA_WIDTH-1:0]   q;
    logic [DATA_WIDTH-1:0]   dout;
    logic [A_HI_SIZE-1:0]    dout_queue;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    busy;

    modport master (
        input  fifo_empty, queue_mask, q, dout_ready,
        output read, read_enable, dout, dout_queue, dout_valid, busy
    );

    modport slave (
        output fifo_empty, queue_mask, q, dout_ready,
        input  read, read_enable, dout, dout_queue, dout_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/fifo_mq_read_sched.sv
// ============================================================================
// Module      : fifo_mq_read_sched
// Description : Read-side round-robin scheduler for the multi-queue async
//               FIFO (read clock domain). Picks a non-empty, unmasked queue,
//               issues a one-cycle read with a one-hot queue select, captures
//               the registered RAM output and presents it downstream with its
//               queue number on a valid/ready handshake.
//               Ports: clk, rst (sync, active high),
//                      bus (master modport): fifo_empty, queue_mask, q,
//                      dout_ready in; read, read_enable, dout, dout_queue,
//                      dout_valid, busy out.
//               Per word: IDLE -> ISSUE -> CAPTURE -> OUT (>= 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_mq_read_sched #(
    parameter int NR_OF_QUEUES = 16,
    parameter int A_HI_SIZE    = 4,
    parameter int DATA_WIDTH   = 36,
    parameter int HOLDOFF      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_mq_read_sched_if.master  bus
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_issue   = 2'd1;
    localparam logic [1:0] c_capture = 2'd2;
    localparam logic [1:0] c_out     = 2'd3;

    localparam logic [2:0]           c_holdoff = 3'(HOLDOFF);
    localparam logic [A_HI_SIZE-1:0] c_rr_init = A_HI_SIZE'(NR_OF_QUEUES - 1);

    logic [1:0]              r_state;
    logic [A_HI_SIZE-1:0]    r_rr;
    logic [A_HI_SIZE-1:0]    r_win;
    logic                    r_read;
    logic [0:NR_OF_QUEUES-1] r_read_enable;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic [A_HI_SIZE-1:0]    r_dout_queue;
    logic                    r_dout_valid;
    logic                    r_busy;
    logic [2:0]              r_hold [NR_OF_QUEUES];

    logic [0:NR_OF_QUEUES-1] w_elig;
    logic [0:NR_OF_QUEUES-1] w_pick_oh;
    logic                    w_found;
    logic [A_HI_SIZE-1:0]    w_pick;

    for (genvar i = 0; i < NR_OF_QUEUES; i++) begin : g_queue
        assign w_elig[i]    = ~bus.fifo_empty[i] & bus.queue_mask[i] & (r_hold[i] == 3'd0);
        assign w_pick_oh[i] = (w_pick == A_HI_SIZE'(i));
    end

    // Round-robin search from r_rr+1 with wrap; r_rr <= N-1 so a single
    // conditional subtract replaces the modulo.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int k = 1; k <= NR_OF_QUEUES; k++) begin
            j = int'(r_rr) + k;
            if (j >= NR_OF_QUEUES) begin
                j = j - NR_OF_QUEUES;
            end
            if (!w_found && w_elig[j]) begin
                w_found = 1'b1;
                w_pick  = A_HI_SIZE'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_rr          <= c_rr_init;
            r_win         <= '0;
            r_read        <= 1'b0;
            r_read_enable <= '0;
            r_dout        <= '0;
            r_dout_queue  <= '0;
            r_dout_valid  <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < NR_OF_QUEUES; i++) begin
                r_hold[i] <= 3'd0;
            end
        end else begin
            // Holdoff counters run independently of the state; the load in
            // ISSUE below overrides the decrement for the winner.
            for (int i = 0; i < NR_OF_QUEUES; i++) begin
                if (r_hold[i] != 3'd0) begin
                    r_hold[i] <= r_hold[i] - 3'd1;
                end
            end

            case (r_state)
                c_idle: begin
                    if (w_found) begin
                        r_state       <= c_issue;
                        r_win         <= w_pick;
                        r_read_enable <= w_pick_oh;
                        r_read        <= 1'b1;
                        r_busy        <= 1'b1;
                    end else begin
                        r_read_enable <= '0;
                    end
                end
                c_issue: begin
                    r_read         <= 1'b0;
                    r_rr           <= r_win;
                    r_hold[r_win]  <= c_holdoff;
                    r_state        <= c_capture;
                end
                c_capture: begin
                    // RAM output is valid now; select dropped once captured.
                    r_dout        <= bus.q;
                    r_dout_queue  <= r_win;
                    r_dout_valid  <= 1'b1;
                    r_read_enable <= '0;
                    r_state       <= c_out;
                end
                c_out: begin
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.read        = r_read;
    assign bus.read_enable = r_read_enable;
    assign bus.dout        = r_dout;
    assign bus.dout_queue  = r_dout_queue;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: doc/fifo_mq_read_sched.md
Name: fifo_mq_read_sched

Overview:
- Read-side scheduler and data-capture engine for the multi-queue async FIFO. Runs in the FIFO read clock domain.
- Watches the per-queue empty flags and picks a non-empty, unmasked queue by round-robin. Drives the FIFO `read`/`read_enable` pair and captures the registered RAM output.
- Presents each word downstream with its queue number on a valid/ready handshake.
- Sits between the FIFO read port and the consumer (e.g. the SDRAM command/data path).

Parameters:
- nr_of_queues, 16, number of queues; width of the one-hot vectors.
- a_hi_size, 4, width of the binary queue number; 2**a_hi_size >= nr_of_queues.
- data_width, 36, FIFO word width.
- holdoff, 2, cycles a just-read queue stays ineligible after its read pulse (covers empty-flag update lag); range 0..7.

Ports:
- clk  in  1  read-domain clock (same as FIFO clk2).
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  [0:nr_of_queues-1]  per-queue empty flags from the FIFO.
- queue_mask  in  [0:nr_of_queues-1]  1 = queue allowed to be scheduled.
- read  out  1  FIFO read strobe.
- read_enable  out  [0:nr_of_queues-1]  one-hot queue select to the FIFO.
- q  in  data_width  FIFO read data, registered, valid one cycle after the read cycle.
- dout  out  data_width  captured word.
- dout_queue  out  a_hi_size  binary number of the source queue.
- dout_valid  out  1  dout/dout_queue valid.
- dout_ready  in  1  consumer accepts when dout_valid & dout_ready.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high, sampled only on the rising clk edge.
- Reset values: state=IDLE, read=0, read_enable=0, dout=0, dout_queue=0, dout_valid=0, busy=0, rr pointer=nr_of_queues-1 (queue 0 searched first), all holdoff counters=0.
- Reset mid-operation: any state returns to IDLE and a pending output word is dropped. Any FIFO read already issued is not replayed, so system reset must reset the FIFO read side as well.
- Eligibility: queue i is eligible when fifo_empty[i]=0, queue_mask[i]=1, and holdoff counter i = 0.
- Round-robin: search starts at rr+1 and wraps modulo nr_of_queues; the first eligible queue wins. rr is updated to the winner at ISSUE.
- State IDLE:
  - Any eligible queue -> ISSUE, with read_enable = onehot(winner) registered.
  - None eligible -> stay in IDLE, read_enable=0.
- State ISSUE (1 cycle):
  - read=1; read_enable held at the winner. The FIFO samples the address and advances that queue's read pointer at the end of this cycle.
  - Holdoff counter of the winner is loaded with holdoff.
  - Next state: CAPTURE.
- State CAPTURE (1 cycle):
  - read=0; read_enable still held so the RAM address is stable.
  - At the end of the cycle: dout<=q, dout_queue<=bin(winner), dout_valid<=1, read_enable<=0.
  - Next state: OUT.
- State OUT:
  - dout_valid=1; dout and dout_queue held stable.
  - dout_ready=1 -> dout_valid<=0 at the end of the cycle, then to IDLE.
  - dout_ready low -> stay in OUT indefinitely (backpressure); no new read is issued.
- Timing: read-to-dout_valid latency is 2 cycles (ISSUE -> CAPTURE -> OUT). Minimum period per word is 4 cycles.
- Holdoff counters decrement by 1 per cycle while nonzero, independent of state. holdoff=0 disables the feature.
- Invariants:
  - read is never asserted unless read_enable is one-hot.
  - read is never asserted to a queue whose fifo_empty was 1 in the IDLE cycle that selected it.
- Masking: mask or empty changes after selection do not abort the transfer in progress.
- Vector ordering: bit 0 of every [0:N-1] vector is queue 0, and dout_queue=0 for queue 0.

Test Plan:
- Single queue: reset, queue 3 non-empty (word 36'h0_1234_5678), dout_ready=1.
  - read high exactly 1 cycle with read_enable=16'b0001_0000_0000_0000 ([0:15] order).
  - dout_valid asserted 2 cycles after read, with dout=36'h012345678 and dout_queue=3.
- Round-robin: queues 0, 5, 9 each hold 2 words, all unmasked.
  - Service order is 0,5,9,0,5,9; all 6 words delivered.
  - Then idle with read never asserted.
- Backpressure: dout_ready=0 for 20 cycles with words pending.
  - dout_valid stays 1, dout stable, no read pulse.
  - On dout_ready=1 the word is accepted and the next read follows.
- Holdoff/mask: only queue 7 non-empty with holdoff=2; then queue 2 with queue_mask[2]=0.
  - Queue 7 is not re-read within 2 cycles of its read pulse.
  - Queue 2 is never read.
- Reset mid-CAPTURE: assert rst during CAPTURE.
  - Next cycle: dout_valid=0, read_enable=0, busy=0.
  - After release, the next grant goes to queue 0 when it is eligible.
